instr_mem_arbiter: RTL and testbench

- Shares one instruction-memory port (syn/ack/last handshake) between two requesters: requester 0 is the fetch stage, requester 1 is the loader/debug port.
- Arbitrates requests, forwards one transaction at a time to memory and returns data to the winner.
- Sits between the fetch stage and the instruction memory.
- Provides round-robin fairness, flush-driven response dropping for requester 0, and a memory-ack timeout.

---
 rtl/instr_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_instr_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_arbiter.sv
// Two-requester arbiter for a single instruction-memory port (syn/ack/last handshake).
// Requester 0 is the fetch stage and requester 1 is the loader/debug port. Ties are
// broken round-robin. A pipeline flush cancels an in-flight requester-0 response, and
// the memory ack wait is bounded by a timeout.
//
// Ports:
//   ima_clk, ima_rst                      clock, asynchronous active-low reset
//   ima_r0_syn / ima_r0_ack / _instr / _last   requester 0 handshake and response
//   ima_r1_syn / ima_r1_ack / _instr / _last   requester 1 handshake and response
//   ima_m_syn / ima_m_ack / _instr / _last     instruction-memory handshake
//   ima_i_flush                           pipeline flush (cancels requester-0 response)
//   ima_o_busy                            high while a transaction is in BUSY or RESP
//   ima_o_grant                           current or most recently granted requester
//   ima_o_timeout                         one-cycle pulse when a transaction is aborted
module instr_mem_arbiter #(
    parameter int unsigned IWIDTH  = 32,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TWIDTH  = 5
) (
    input  logic              ima_clk,
    input  logic              ima_rst,
    input  logic              ima_r0_syn,
    output logic              ima_r0_ack,
    output logic [IWIDTH-1:0] ima_r0_instr,
    output logic              ima_r0_last,
    input  logic              ima_r1_syn,
    output logic              ima_r1_ack,
    output logic [IWIDTH-1:0] ima_r1_instr,
    output logic              ima_r1_last,
    output logic              ima_m_syn,
    input  logic              ima_m_ack,
    input  logic [IWIDTH-1:0] ima_m_instr,
    input  logic              ima_m_last,
    input  logic              ima_i_flush,
    output logic              ima_o_busy,
    output logic              ima_o_grant,
    output logic              ima_o_timeout
);

    localparam logic [TWIDTH-1:0] TLIMIT = TWIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [TWIDTH-1:0] tcnt;
    logic              drop;
    logic              win_c;

    // Single request wins outright; on a tie the requester not granted last time wins.
    assign win_c = (ima_r0_syn && ima_r1_syn) ? ~ima_o_grant : ima_r1_syn;

    // Arbitration FSM with registered outputs.
    always_ff @(posedge ima_clk or negedge ima_rst) begin
        if (!ima_rst) begin
            state         <= IDLE;
            tcnt          <= '0;
            drop          <= 1'b0;
            ima_r0_ack    <= 1'b0;
            ima_r0_instr  <= '0;
            ima_r0_last   <= 1'b0;
            ima_r1_ack    <= 1'b0;
            ima_r1_instr  <= '0;
            ima_r1_last   <= 1'b0;
            ima_m_syn     <= 1'b0;
            ima_o_busy    <= 1'b0;
            ima_o_grant   <= 1'b1;
            ima_o_timeout <= 1'b0;
        end else begin
            // Strobes default low; only the branches below raise them.
            ima_r0_ack    <= 1'b0;
            ima_r1_ack    <= 1'b0;
            ima_o_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (ima_r0_syn || ima_r1_syn) begin
                        ima_o_grant <= win_c;
                        ima_m_syn   <= 1'b1;
                        ima_o_busy  <= 1'b1;
                        tcnt        <= '0;
                        state       <= BUSY;
                    end
                end

                BUSY: begin
                    // Flush only concerns the fetch stage's outstanding response.
                    if (ima_i_flush && !ima_o_grant) begin
                        drop <= 1'b1;
                    end
                    if (ima_m_ack) begin
                        ima_m_syn <= 1'b0;
                        state     <= RESP;
                        if (ima_o_grant) begin
                            ima_r1_instr <= ima_m_instr;
                            ima_r1_last  <= ima_m_last;
                            ima_r1_ack   <= ~drop;
                        end else begin
                            ima_r0_instr <= ima_m_instr;
                            ima_r0_last  <= ima_m_last;
                            ima_r0_ack   <= ~(drop || ima_i_flush);
                        end
                    end else if (tcnt == TLIMIT) begin
                        // Abort: memory never answered within the budget.
                        ima_m_syn     <= 1'b0;
                        ima_o_timeout <= 1'b1;
                        ima_o_busy    <= 1'b0;
                        drop          <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        tcnt <= tcnt + TWIDTH'(1);
                    end
                end

                RESP: begin
                    drop       <= 1'b0;
                    ima_o_busy <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    ima_m_syn  <= 1'b0;
                    ima_o_busy <= 1'b0;
                    drop       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Directed self-checking bench for instr_mem_arbiter.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_instr_mem_arbiter;

    localparam int unsigned IWIDTH  = 32;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned TWIDTH  = 5;

    logic              ima_clk;
    logic              ima_rst;
    logic              ima_r0_syn;
    logic              ima_r0_ack;
    logic [IWIDTH-1:0] ima_r0_instr;
    logic              ima_r0_last;
    logic              ima_r1_syn;
    logic              ima_r1_ack;
    logic [IWIDTH-1:0] ima_r1_instr;
    logic              ima_r1_last;
    logic              ima_m_syn;
    logic              ima_m_ack;
    logic [IWIDTH-1:0] ima_m_instr;
    logic              ima_m_last;
    logic              ima_i_flush;
    logic              ima_o_busy;
    logic              ima_o_grant;
    logic              ima_o_timeout;

    int checks = 0;
    int errors = 0;

    instr_mem_arbiter #(
        .IWIDTH (IWIDTH),
        .TIMEOUT(TIMEOUT),
        .TWIDTH (TWIDTH)
    ) dut (
        .ima_clk      (ima_clk),
        .ima_rst      (ima_rst),
        .ima_r0_syn   (ima_r0_syn),
        .ima_r0_ack   (ima_r0_ack),
        .ima_r0_instr (ima_r0_instr),
        .ima_r0_last  (ima_r0_last),
        .ima_r1_syn   (ima_r1_syn),
        .ima_r1_ack   (ima_r1_ack),
        .ima_r1_instr (ima_r1_instr),
        .ima_r1_last  (ima_r1_last),
        .ima_m_syn    (ima_m_syn),
        .ima_m_ack    (ima_m_ack),
        .ima_m_instr  (ima_m_instr),
        .ima_m_last   (ima_m_last),
        .ima_i_flush  (ima_i_flush),
        .ima_o_busy   (ima_o_busy),
        .ima_o_grant  (ima_o_grant),
        .ima_o_timeout(ima_o_timeout)
    );

    initial ima_clk = 1'b0;
    always #5 ima_clk = ~ima_clk;

    // Hard stop in case a scenario gets stuck.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge ima_clk);
        #1;
    endtask

    task automatic apply_reset();
        ima_rst     = 1'b0;
        ima_r0_syn  = 1'b0;
        ima_r1_syn  = 1'b0;
        ima_m_ack   = 1'b0;
        ima_m_instr = '0;
        ima_m_last  = 1'b0;
        ima_i_flush = 1'b0;
        repeat (2) @(posedge ima_clk);
        @(negedge ima_clk);
        ima_rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (ima_o_grant !== 1'b1) begin errors++; $display("FAIL reset_grant: got %0b want 1", ima_o_grant); end
        checks++; if (ima_m_syn !== 1'b0) begin errors++; $display("FAIL reset_m_syn: got %0b want 0", ima_m_syn); end
        checks++; if (ima_o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", ima_o_busy); end
        checks++; if ({ima_r0_ack, ima_r1_ack, ima_o_timeout} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b want 000", {ima_r0_ack, ima_r1_ack, ima_o_timeout}); end
        checks++; if ({ima_r0_instr, ima_r1_instr} !== 64'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", {ima_r0_instr, ima_r1_instr}); end
        checks++; if ({ima_r0_last, ima_r1_last} !== 2'b00) begin errors++; $display("FAIL reset_last: got %b want 00", {ima_r0_last, ima_r1_last}); end
    endtask

    // Single requester 0 fetch: m_syn in cycles 1-3, ack in cycle 4.
    task automatic test_single_r0();
        apply_reset();
        ima_r0_syn = 1'b1;                       // cycle 0
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++; if (ima_m_syn !== 1'b1) begin errors++; $display("FAIL single_m_syn_c%0d: got %0b want 1", c, ima_m_syn); end
            checks++; if (ima_r0_ack !== 1'b0) begin errors++; $display("FAIL single_early_ack_c%0d: got %0b want 0", c, ima_r0_ack); end
        end
        ima_m_ack   = 1'b1;                      // memory answers in cycle 3
        ima_m_instr = 32'h0050_0093;
        ima_m_last  = 1'b0;
        tick();                                  // cycle 4
        checks++; if (ima_r0_ack !== 1'b1) begin errors++; $display("FAIL single_r0_ack: got %0b want 1", ima_r0_ack); end
        checks++; if (ima_r0_instr !== 32'h0050_0093) begin errors++; $display("FAIL single_r0_instr: got %h want 00500093", ima_r0_instr); end
        checks++; if (ima_r1_ack !== 1'b0) begin errors++; $display("FAIL single_r1_ack: got %0b want 0", ima_r1_ack); end
        checks++; if (ima_o_grant !== 1'b0) begin errors++; $display("FAIL single_grant: got %0b want 0", ima_o_grant); end
        checks++; if (ima_m_syn !== 1'b0) begin errors++; $display("FAIL single_m_syn_off: got %0b want 0", ima_m_syn); end
        ima_r0_syn = 1'b0;
        ima_m_ack  = 1'b0;
        tick();
        checks++; if (ima_r0_ack !== 1'b0) begin errors++; $display("FAIL single_ack_width: got %0b want 0", ima_r0_ack); end
        checks++; if (ima_o_busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %0b want 0", ima_o_busy); end
    endtask

    // Both requesters held high: grants alternate 0,1,0,1 with one idle cycle between.
    task automatic test_round_robin();
        logic exp_g;
        apply_reset();
        ima_r0_syn = 1'b1;
        ima_r1_syn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2) == 1;
            tick();                              // BUSY
            checks++; if (ima_o_grant !== exp_g) begin errors++; $display("FAIL rr_grant_%0d: got %0b want %0b", i, ima_o_grant, exp_g); end
            checks++; if (ima_o_busy !== 1'b1) begin errors++; $display("FAIL rr_busy_%0d: got %0b want 1", i, ima_o_busy); end
            ima_m_ack   = 1'b1;
            ima_m_instr = 32'h1000_0000 + 32'(i);
            tick();                              // RESP
            checks++; if ({ima_r1_ack, ima_r0_ack} !== (exp_g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_ack_%0d: got %b want %b", i, {ima_r1_ack, ima_r0_ack}, (exp_g ? 2'b10 : 2'b01)); end
            checks++; if ((exp_g ? ima_r1_instr : ima_r0_instr) !== 32'h1000_0000 + 32'(i)) begin errors++; $display("FAIL rr_instr_%0d: got %h want %h", i, (exp_g ? ima_r1_instr : ima_r0_instr), 32'h1000_0000 + 32'(i)); end
            ima_m_ack = 1'b0;
            tick();                              // IDLE
            checks++; if ({ima_r1_ack, ima_r0_ack} !== 2'b00) begin errors++; $display("FAIL rr_ack_width_%0d: got %b want 00", i, {ima_r1_ack, ima_r0_ack}); end
            checks++; if (ima_o_busy !== 1'b0) begin errors++; $display("FAIL rr_busy_gap_%0d: got %0b want 0", i, ima_o_busy); end
        end
        ima_r0_syn = 1'b0;
        ima_r1_syn = 1'b0;
        tick();
    endtask

    // Flush before m_ack drops the response; a retry then completes; flush on the ack cycle also drops.
    task automatic test_flush();
        apply_reset();
        ima_r0_syn = 1'b1;
        tick();                                  // BUSY
        ima_i_flush = 1'b1;
        tick();
        ima_i_flush = 1'b0;
        ima_m_ack   = 1'b1;
        ima_m_instr = 32'hDEAD_BEEF;
        tick();                                  // RESP, dropped
        checks++; if (ima_r0_ack !== 1'b0) begin errors++; $display("FAIL flush_r0_ack: got %0b want 0", ima_r0_ack); end
        checks++; if (ima_r0_instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL flush_r0_instr: got %h want deadbeef", ima_r0_instr); end
        ima_m_ack = 1'b0;
        tick();                                  // IDLE, r0_syn still high
        checks++; if (ima_o_busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy: got %0b want 0", ima_o_busy); end
        tick();                                  // BUSY again
        checks++; if (ima_m_syn !== 1'b1 || ima_o_grant !== 1'b0) begin errors++; $display("FAIL flush_retry_req: got m_syn=%0b grant=%0b want 1/0", ima_m_syn, ima_o_grant); end
        ima_m_ack   = 1'b1;
        ima_m_instr = 32'h1234_5678;
        tick();
        checks++; if (ima_r0_ack !== 1'b1) begin errors++; $display("FAIL flush_retry_ack: got %0b want 1", ima_r0_ack); end
        checks++; if (ima_r0_instr !== 32'h1234_5678) begin errors++; $display("FAIL flush_retry_instr: got %h want 12345678", ima_r0_instr); end
        ima_m_ack = 1'b0;
        tick();                                  // IDLE, r0 re-requests
        tick();                                  // BUSY
        ima_m_ack   = 1'b1;
        ima_i_flush = 1'b1;                      // flush coincides with m_ack
        ima_m_instr = 32'h0BAD_0BAD;
        tick();
        checks++; if (ima_r0_ack !== 1'b0) begin errors++; $display("FAIL flush_same_cycle_ack: got %0b want 0", ima_r0_ack); end
        ima_m_ack   = 1'b0;
        ima_i_flush = 1'b0;
        ima_r0_syn  = 1'b0;
        tick();
    endtask

    // No memory ack: m_syn high 16 cycles then one timeout pulse; ack on the limit cycle beats timeout.
    task automatic test_timeout();
        apply_reset();
        ima_r0_syn = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            checks++; if (ima_m_syn !== 1'b1 || ima_o_timeout !== 1'b0) begin errors++; $display("FAIL to_wait_c%0d: got m_syn=%0b timeout=%0b want 1/0", c, ima_m_syn, ima_o_timeout); end
        end
        tick();
        checks++; if (ima_o_timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %0b want 1", ima_o_timeout); end
        checks++; if (ima_m_syn !== 1'b0) begin errors++; $display("FAIL to_m_syn_off: got %0b want 0", ima_m_syn); end
        checks++; if ({ima_r0_ack, ima_r1_ack, ima_o_busy} !== 3'b000) begin errors++; $display("FAIL to_no_ack: got %b want 000", {ima_r0_ack, ima_r1_ack, ima_o_busy}); end
        tick();                                  // accepts the still-pending request
        checks++; if (ima_o_timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %0b want 0", ima_o_timeout); end
        checks++; if (ima_m_syn !== 1'b1) begin errors++; $display("FAIL to_next_req: got %0b want 1", ima_m_syn); end
        repeat (15) tick();                      // counter now at its limit
        ima_m_ack   = 1'b1;
        ima_m_instr = 32'h0000_0013;
        tick();
        checks++; if (ima_r0_ack !== 1'b1 || ima_o_timeout !== 1'b0) begin errors++; $display("FAIL to_ack_wins: got ack=%0b timeout=%0b want 1/0", ima_r0_ack, ima_o_timeout); end
        ima_m_ack  = 1'b0;
        ima_r0_syn = 1'b0;
        tick();
        checks++; if (ima_o_timeout !== 1'b0) begin errors++; $display("FAIL to_late_pulse: got %0b want 0", ima_o_timeout); end
    endtask

    // Requester 1 response with last=1; a flush during its transaction is ignored.
    task automatic test_r1_last();
        apply_reset();
        ima_r1_syn = 1'b1;
        tick();
        checks++; if (ima_o_grant !== 1'b1) begin errors++; $display("FAIL r1_grant: got %0b want 1", ima_o_grant); end
        ima_i_flush = 1'b1;
        tick();
        ima_i_flush = 1'b0;
        ima_m_ack   = 1'b1;
        ima_m_instr = 32'hCAFE_F00D;
        ima_m_last  = 1'b1;
        tick();
        checks++; if (ima_r1_ack !== 1'b1 || ima_r1_last !== 1'b1) begin errors++; $display("FAIL r1_ack_last: got ack=%0b last=%0b want 1/1", ima_r1_ack, ima_r1_last); end
        checks++; if (ima_r1_instr !== 32'hCAFE_F00D) begin errors++; $display("FAIL r1_instr: got %h want cafef00d", ima_r1_instr); end
        checks++; if ({ima_r0_ack, ima_r0_last, ima_r0_instr} !== 34'h0) begin errors++; $display("FAIL r1_r0_unchanged: got %h want 0", {ima_r0_ack, ima_r0_last, ima_r0_instr}); end
        ima_m_ack  = 1'b0;
        ima_m_last = 1'b0;
        ima_r1_syn = 1'b0;
        tick();
        checks++; if (ima_r1_last !== 1'b1 || ima_r1_ack !== 1'b0) begin errors++; $display("FAIL r1_last_hold: got last=%0b ack=%0b want 1/0", ima_r1_last, ima_r1_ack); end
    endtask

    // Async reset during BUSY clears everything immediately; afterwards a tie goes to requester 0.
    task automatic test_async_reset();
        ima_r0_syn = 1'b1;
        tick();                                  // BUSY with grant 0
        #2;
        ima_rst = 1'b0;
        #1;
        checks++; if (ima_m_syn !== 1'b0 || ima_o_busy !== 1'b0) begin errors++; $display("FAIL areset_m_syn_busy: got %0b/%0b want 0/0", ima_m_syn, ima_o_busy); end
        checks++; if (ima_o_grant !== 1'b1) begin errors++; $display("FAIL areset_grant: got %0b want 1", ima_o_grant); end
        checks++; if ({ima_r1_instr, ima_r1_last} !== 33'h0) begin errors++; $display("FAIL areset_r1_regs: got %h want 0", {ima_r1_instr, ima_r1_last}); end
        ima_r1_syn = 1'b1;
        @(negedge ima_clk);
        ima_rst = 1'b1;
        tick();
        checks++; if (ima_o_grant !== 1'b0 || ima_m_syn !== 1'b1) begin errors++; $display("FAIL areset_tie_grant: got grant=%0b m_syn=%0b want 0/1", ima_o_grant, ima_m_syn); end
        ima_r0_syn = 1'b0;
        ima_r1_syn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_r0();
        test_round_robin();
        test_flush();
        test_timeout();
        test_r1_last();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
